// File: rtl/frame_store_pkg.sv
// frame_store_pkg: shared state encoding and constants for the frame-store responder
package frame_store_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, ACK = 2'd2} state_t;
    localparam logic [3:0] NBYTE_NONE = 4'b1111;
    localparam int LANE_W = 8;
    localparam int DEPTH_DEFAULT = 76800;
endpackage

// File: rtl/frame_store_ram.sv
// frame_store_ram: single-port word array with per-lane writes and a held registered read
module frame_store_ram
    import frame_store_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [3:0]    lane_en,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (lane_en[i]) mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/frame_store_responder.sv
// frame_store_responder: drawing-engine port responder with wait states over a frame-store array
module frame_store_responder
    import frame_store_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              de_req,
    output logic              de_ack,
    input  logic [ADDR_W-1:0] de_addr,
    input  logic [3:0]        de_nbyte,
    input  logic              de_rnw,
    input  logic [31:0]       de_w_data,
    output logic [31:0]       de_r_data,
    output logic              busy,
    output logic              range_err,
    output logic [15:0]       wr_count
);
    localparam int AW = $clog2(DEPTH);

    state_t state;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0] req_nbyte;
    logic req_rnw;
    logic [31:0] req_wdata;
    logic rd_zero;
    logic [31:0] ram_rdata;
    logic idle, go_ack, c_rnw, c_in, ram_we, ram_re;
    logic [ADDR_W-1:0] c_addr;
    logic [3:0] c_nbyte;
    logic [31:0] c_wdata;

    // With zero wait states the commit happens on the capture edge, so it must see the live inputs
    always_comb begin
        idle = state == IDLE;
        go_ack = idle ? de_req && WAIT_STATES == 0 : state == WAIT && cnt == 4'd1;
        c_addr = idle ? de_addr : req_addr;
        c_nbyte = idle ? de_nbyte : req_nbyte;
        c_rnw = idle ? de_rnw : req_rnw;
        c_wdata = idle ? de_w_data : req_wdata;
        c_in = c_addr < ADDR_W'(DEPTH);
        ram_we = go_ack && !reset && !c_rnw && c_in;
        ram_re = go_ack && !reset && c_rnw && c_in;
    end

    frame_store_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk(clk),
        .we(ram_we),
        .re(ram_re),
        .lane_en(~c_nbyte),
        .addr(c_addr[AW-1:0]),
        .wdata(c_wdata),
        .rdata(ram_rdata)
    );

    assign de_ack = state == ACK;
    assign busy = state != IDLE;
    assign de_r_data = rd_zero ? '0 : ram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            range_err <= 1'b0;
            wr_count <= '0;
            rd_zero <= 1'b1;
        end else begin
            if (go_ack) begin
                if (!c_in) range_err <= 1'b1;
                if (c_rnw) rd_zero <= !c_in;
                else if (c_in && c_nbyte != NBYTE_NONE && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end
            case (state)
                IDLE: if (de_req) begin
                    req_addr <= de_addr;
                    req_nbyte <= de_nbyte;
                    req_rnw <= de_rnw;
                    req_wdata <= de_w_data;
                    cnt <= 4'(WAIT_STATES);
                    state <= WAIT_STATES == 0 ? ACK : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ACK;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
